object_table_ctrl: RTL and testbench
====================================

# object_table_ctrl

Clocked controller for the CPU→hardware object-table handshake. It synchronises the software phase code, captures x/y/state words from the PIO ports into a shadow bank, and acknowledges each phase. On the next frame-start pulse after a complete X/Y/STATE set, it commits the shadow bank to an active bank, so the sprite/draw logic never sees a torn frame. It sits between the NIOS PIO ports and the object renderers.

## Interface
- NUM_OBJ, 15: object slots 1..NUM_OBJ; port 0 is the control word.
- Y_FLIP, 480: y-axis flip constant.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- to_hw_ports  in  (NUM_OBJ+1)×32  PIO data words; index 0 is the control word.
- to_hw_sig  in  2  software phase code: 0 idle, 1 X, 2 Y, 3 STATE.
- frame_start  in  1  one-cycle pulse at vertical blank.
- to_sw_sig  out  2  acknowledge, echoing the captured phase code.
- x_coord  out  NUM_OBJ×10  active-bank x.
- y_coord  out  NUM_OBJ×10  active-bank flipped y.
- obj_state  out  NUM_OBJ×3  active-bank state.
- num_active  out  4  active object count.
- frame_committed  out  1  one-cycle pulse when the active bank updates.
- proto_err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Input conditioning:
  - to_hw_sig passes through a 2-flop synchroniser.
  - code_stable is set when the synchronised value equals its previous-cycle value.
- FSM states:
  - IDLE: a stable nonzero code moves to CAPTURE with phase latched.
  - CAPTURE: one cycle. Writes the shadow fields for the latched phase, sets that bit in phase_mask, then moves to ACK.
  - ACK: to_sw_sig = phase. A stable zero code moves to IDLE. A stable nonzero code different from phase sets proto_err and is otherwise ignored.
- Capture rules, per object i:
  - X: x_sh[i] = port[i][9:0].
  - Y: y_sh[i] = (Y_FLIP − port[i][9:0]) mod 1024. The subtraction is 10-bit and wraps; no saturation.
  - STATE: st_sh[i] = port[i][2:0], and num_sh = min(port0[3:0], NUM_OBJ).
- Re-sending a phase already in phase_mask overwrites the shadow. It is legal and not an error.
- Commit: on frame_start with phase_mask == 3'b111:
  - Active bank is loaded from the shadow.
  - Objects with index > num_sh get obj_state forced to 0.
  - frame_committed pulses and phase_mask clears.
  - With an incomplete mask, frame_start is ignored and the active bank holds.
- Simultaneous CAPTURE and commit:
  - Commit copies the pre-edge shadow.
  - mask_next = (commit ? 0 : mask) | capture_bit, so the new phase is kept for the next frame.
  - A phase-3 capture in the commit cycle does not count toward that commit.

## Timing
- Reset: all outputs are 0, the shadow bank is 0, phase_mask is 0 and the FSM is in IDLE.
- Acquire latency, with to_hw_sig changing before edge 0:
  - sync valid at edge 2, stable at edge 3;
  - CAPTURE at edge 4;
  - to_sw_sig valid after edge 5.
- Release latency: from to_hw_sig = 0 to to_sw_sig = 0 is 4 edges.
- Active bank and frame_committed update on the edge where frame_start is sampled, i.e. 1 cycle.
- Reset mid-handshake: returns to IDLE with to_sw_sig = 0. Software must restart from phase 1.

## Structure
- obj_table_pkg:
  - constants COORD_W = 10, STATE_W = 3, CNT_W = 4;
  - enum phase_e {PH_NONE, PH_X, PH_Y, PH_STATE};
  - FSM enum {IDLE, CAPTURE, ACK}.
- Sub-module sig_sync_stable: parameterised width; 2-flop sync plus previous-value compare; outputs sync_val and stable.

## Test plan
- Full handshake: X port1 = 100, Y port1 = 80, STATE port1 = 5, port0 = 1, then frame_start → x_coord[1] = 100, y_coord[1] = 400, obj_state[1] = 5, frame_committed for 1 cycle; to_sw_sig = 1 five cycles after the sig change.
- Incomplete set: X and Y only, then frame_start → active bank unchanged, no frame_committed; STATE then frame_start → commit.
- Wrap: Y port = 500 → y_coord = 1004.
- Protocol error: hold to_hw_sig = 1, switch it to 2 without returning to 0 → proto_err = 1, to_sw_sig stays 1, no Y capture.
- Collision: phase-1 capture in the same cycle as a commit → committed x is the old shadow, phase_mask = 3'b001 afterward.
- Count mask and reset: port0 = 3 with all states = 7 → obj_state[4..15] = 0; assert reset during ACK → all outputs 0 within 1 cycle.

Source files
------------

// File: rtl/object_table_ctrl_pkg.sv
// Shared widths, phase codes and FSM encoding for the object-table handshake controller.
package obj_table_pkg;
  localparam int COORD_W = 10;
  localparam int STATE_W = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {PH_NONE, PH_X, PH_Y, PH_STATE} phase_e;
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} fsm_e;
endpackage

// File: rtl/object_table_ctrl_if.sv
// Bundle of PIO words, phase handshake, frame strobe and active-bank outputs.
interface object_table_ctrl_if #(
  parameter int NUM_OBJ = 15
);
  import obj_table_pkg::*;

  logic [NUM_OBJ:0][31:0]        to_hw_ports;
  logic [1:0]                    to_hw_sig;
  logic                          frame_start;
  logic [1:0]                    to_sw_sig;
  logic [NUM_OBJ:1][COORD_W-1:0] x_coord;
  logic [NUM_OBJ:1][COORD_W-1:0] y_coord;
  logic [NUM_OBJ:1][STATE_W-1:0] obj_state;
  logic [CNT_W-1:0]              num_active;
  logic                          frame_committed;
  logic                          proto_err;

  modport master (
    output to_hw_ports, to_hw_sig, frame_start,
    input  to_sw_sig, x_coord, y_coord, obj_state, num_active, frame_committed, proto_err
  );

  modport slave (
    input  to_hw_ports, to_hw_sig, frame_start,
    output to_sw_sig, x_coord, y_coord, obj_state, num_active, frame_committed, proto_err
  );
endinterface

// File: rtl/object_table_ctrl_sync.sv
// Two-flop synchroniser followed by a registered value/stability pair.
module sig_sync_stable #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync_val,
  output logic         stable
);
  logic [W-1:0] meta;
  logic [W-1:0] sync;

  // stable is registered with sync_val so the flag always describes the value presented with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= '0;
      sync     <= '0;
      sync_val <= '0;
      stable   <= 1'b0;
    end else begin
      meta     <= d;
      sync     <= meta;
      sync_val <= sync;
      stable   <= (sync == sync_val);
    end
  end
endmodule

// File: rtl/object_table_ctrl.sv
// Phase-handshake capture into a shadow bank, committed atomically to the active bank on frame start.
module object_table_ctrl
  import obj_table_pkg::*;
#(
  parameter int NUM_OBJ = 15,
  parameter int Y_FLIP  = 480
) (
  input logic                clk,
  input logic                reset,
  object_table_ctrl_if.slave bus
);
  function automatic logic [COORD_W-1:0] flip_y(input logic [COORD_W-1:0] raw);
    return COORD_W'(Y_FLIP) - raw;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] raw);
    return (int'(raw) > NUM_OBJ) ? CNT_W'(NUM_OBJ) : raw;
  endfunction

  logic [1:0] sig_val;
  logic       sig_stable;
  fsm_e       state, state_nxt;
  phase_e     phase, phase_nxt;
  logic       capture, err_set, commit;
  logic [2:0] mask, mask_nxt, capture_bit;

  logic [NUM_OBJ:1][COORD_W-1:0] x_sh, y_sh, x_act, y_act;
  logic [NUM_OBJ:1][STATE_W-1:0] st_sh, st_act;
  logic [CNT_W-1:0]              num_sh, num_act;
  logic                          committed, err;

  sig_sync_stable #(.W(2)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .d        (bus.to_hw_sig),
    .sync_val (sig_val),
    .stable   (sig_stable)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phase <= PH_NONE;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    capture   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (sig_stable && sig_val != 2'd0) begin
          phase_nxt = phase_e'(sig_val);
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        if (sig_stable) begin
          if (sig_val == 2'd0)
            state_nxt = IDLE;
          else if (sig_val != phase)
            err_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture_bit = 3'b000;
    if (capture) begin
      case (phase)
        PH_X:     capture_bit = 3'b001;
        PH_Y:     capture_bit = 3'b010;
        PH_STATE: capture_bit = 3'b100;
        default:  capture_bit = 3'b000;
      endcase
    end
  end

  // A capture landing on the commit edge survives into the next frame's mask
  assign commit   = bus.frame_start && (mask == 3'b111);
  assign mask_nxt = (commit ? 3'b000 : mask) | capture_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sh      <= '0;
      y_sh      <= '0;
      st_sh     <= '0;
      num_sh    <= '0;
      x_act     <= '0;
      y_act     <= '0;
      st_act    <= '0;
      num_act   <= '0;
      mask      <= '0;
      committed <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 1; i <= NUM_OBJ; i++) begin
          case (phase)
            PH_X:     x_sh[i]  <= bus.to_hw_ports[i][COORD_W-1:0];
            PH_Y:     y_sh[i]  <= flip_y(bus.to_hw_ports[i][COORD_W-1:0]);
            PH_STATE: st_sh[i] <= bus.to_hw_ports[i][STATE_W-1:0];
            default: ;
          endcase
        end
        if (phase == PH_STATE)
          num_sh <= clamp_count(bus.to_hw_ports[0][CNT_W-1:0]);
      end
      if (commit) begin
        x_act   <= x_sh;
        y_act   <= y_sh;
        num_act <= num_sh;
        for (int i = 1; i <= NUM_OBJ; i++)
          st_act[i] <= (i > int'(num_sh)) ? '0 : st_sh[i];
      end
      committed <= commit;
      mask      <= mask_nxt;
      if (err_set)
        err <= 1'b1;
    end
  end

  assign bus.to_sw_sig       = (state == ACK) ? phase : PH_NONE;
  assign bus.x_coord         = x_act;
  assign bus.y_coord         = y_act;
  assign bus.obj_state       = st_act;
  assign bus.num_active      = num_act;
  assign bus.frame_committed = committed;
  assign bus.proto_err       = err;
endmodule

// File: tb/tb_object_table_ctrl.sv
// Scoreboard bench: stimulus queues expected acks/commits, a negedge monitor pops and compares them.
module tb_object_table_ctrl;
  localparam int NUM_OBJ = 15;

  typedef struct {
    logic [9:0] x1, y1;
    logic [2:0] st1, st3, st4;
    logic [3:0] num;
  } commit_t;

  typedef struct {
    logic [1:0] val;
    int         cyc;
  } ack_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   commits = 0;
  logic [1:0] last_ack = 2'd0;
  commit_t cq[$];
  ack_t    aq[$];

  object_table_ctrl_if #(.NUM_OBJ(NUM_OBJ)) bus ();

  object_table_ctrl #(.NUM_OBJ(NUM_OBJ), .Y_FLIP(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ack(input logic [1:0] v, input int c);
    ack_t a;
    a.val = v;
    a.cyc = c;
    aq.push_back(a);
  endtask

  task automatic push_commit(input logic [9:0] x1, input logic [9:0] y1, input logic [2:0] st1,
                             input logic [2:0] st3, input logic [2:0] st4, input logic [3:0] num);
    commit_t e;
    e.x1 = x1; e.y1 = y1; e.st1 = st1; e.st3 = st3; e.st4 = st4; e.num = num;
    cq.push_back(e);
  endtask

  task automatic set_ports(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] fill);
    bus.to_hw_ports[0] = p0;
    bus.to_hw_ports[1] = p1;
    for (int i = 2; i <= NUM_OBJ; i++) bus.to_hw_ports[i] = fill;
  endtask

  // One full phase handshake; with collide set, frame_start is pulsed on the capture edge.
  task automatic do_phase(input logic [1:0] p, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] fill, input bit collide);
    @(negedge clk);
    set_ports(p0, p1, fill);
    push_ack(p, cyc + 6);
    bus.to_hw_sig = p;
    if (collide) begin
      repeat (5) @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      @(negedge clk);
    end else begin
      repeat (7) @(negedge clk);
    end
    push_ack(2'd0, cyc + 5);
    bus.to_hw_sig = 2'd0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_to_sw_sig"}, {30'd0, bus.to_sw_sig}, 0);
    chk({tag, "_x_zero"}, {31'd0, |bus.x_coord}, 0);
    chk({tag, "_y_zero"}, {31'd0, |bus.y_coord}, 0);
    chk({tag, "_state_zero"}, {31'd0, |bus.obj_state}, 0);
    chk({tag, "_num_active"}, {28'd0, bus.num_active}, 0);
    chk({tag, "_committed"}, {31'd0, bus.frame_committed}, 0);
    chk({tag, "_proto_err"}, {31'd0, bus.proto_err}, 0);
  endtask

  always @(negedge clk) begin
    #1;
    if (bus.frame_committed) begin
      commit_t e;
      commits++;
      if (cq.size() == 0) begin
        chk("unexpected_commit", 1, 0);
      end else begin
        e = cq.pop_front();
        chk("commit_x1", {22'd0, bus.x_coord[1]}, {22'd0, e.x1});
        chk("commit_y1", {22'd0, bus.y_coord[1]}, {22'd0, e.y1});
        chk("commit_st1", {29'd0, bus.obj_state[1]}, {29'd0, e.st1});
        chk("commit_st3", {29'd0, bus.obj_state[3]}, {29'd0, e.st3});
        chk("commit_st4", {29'd0, bus.obj_state[4]}, {29'd0, e.st4});
        chk("commit_num", {28'd0, bus.num_active}, {28'd0, e.num});
      end
    end
    if (bus.to_sw_sig !== last_ack) begin
      ack_t a;
      if (aq.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.to_sw_sig}, {30'd0, last_ack});
      end else begin
        a = aq.pop_front();
        chk("ack_value", {30'd0, bus.to_sw_sig}, {30'd0, a.val});
        if (a.cyc >= 0) chk("ack_latency", cyc, a.cyc);
      end
      last_ack = bus.to_sw_sig;
    end
  end

  initial begin
    bus.to_hw_sig   = 2'd0;
    bus.frame_start = 1'b0;
    set_ports(0, 0, 0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Full handshake: X=100, Y=80 -> 400, STATE=5 with one active object
    do_phase(2'd1, 0, 100, 0, 1'b0);
    do_phase(2'd2, 0, 80, 0, 1'b0);
    do_phase(2'd3, 1, 5, 6, 1'b0);
    push_commit(10'd100, 10'd400, 3'd5, 3'd0, 3'd0, 4'd1);
    pulse_frame();

    // Incomplete set is ignored; Y=500 wraps to 1004
    do_phase(2'd1, 0, 200, 0, 1'b0);
    do_phase(2'd2, 0, 500, 0, 1'b0);
    pulse_frame();
    chk("incomplete_commits", commits, 1);
    chk("incomplete_x_hold", {22'd0, bus.x_coord[1]}, 100);
    chk("incomplete_y_hold", {22'd0, bus.y_coord[1]}, 400);
    do_phase(2'd3, 15, 2, 7, 1'b0);
    push_commit(10'd200, 10'd1004, 3'd2, 3'd7, 3'd7, 4'd15);
    pulse_frame();

    // Protocol error: 1 -> 2 without passing through 0
    @(negedge clk);
    set_ports(0, 300, 0);
    push_ack(2'd1, cyc + 6);
    bus.to_hw_sig = 2'd1;
    repeat (7) @(negedge clk);
    bus.to_hw_ports[1] = 77;
    bus.to_hw_sig = 2'd2;
    repeat (8) @(negedge clk);
    chk("proto_err_set", {31'd0, bus.proto_err}, 1);
    chk("proto_ack_held", {30'd0, bus.to_sw_sig}, 1);
    push_ack(2'd0, cyc + 5);
    bus.to_hw_sig = 2'd0;
    repeat (6) @(negedge clk);
    do_phase(2'd3, 2, 4, 6, 1'b0);
    pulse_frame();
    chk("no_y_capture_commits", commits, 2);
    chk("no_y_capture_x_hold", {22'd0, bus.x_coord[1]}, 200);
    do_phase(2'd2, 0, 30, 0, 1'b0);
    push_commit(10'd300, 10'd450, 3'd4, 3'd0, 3'd0, 4'd2);
    pulse_frame();

    // Collision: X capture on the commit edge; commit takes the old shadow, X carries over
    do_phase(2'd2, 0, 100, 0, 1'b0);
    do_phase(2'd3, 3, 1, 5, 1'b0);
    do_phase(2'd1, 0, 123, 0, 1'b0);
    push_commit(10'd123, 10'd380, 3'd1, 3'd5, 3'd0, 4'd3);
    do_phase(2'd1, 0, 555, 0, 1'b1);
    chk("collision_commits", commits, 4);
    do_phase(2'd2, 0, 0, 0, 1'b0);
    do_phase(2'd3, 3, 7, 7, 1'b0);
    push_commit(10'd555, 10'd480, 3'd7, 3'd7, 3'd0, 4'd3);
    pulse_frame();
    chk("proto_err_sticky", {31'd0, bus.proto_err}, 1);

    // Reset while acknowledging
    @(negedge clk);
    set_ports(0, 9, 0);
    push_ack(2'd1, cyc + 6);
    bus.to_hw_sig = 2'd1;
    repeat (7) @(negedge clk);
    push_ack(2'd0, -1);
    reset = 1'b1;
    #2;
    check_zero("midreset");
    @(negedge clk);
    bus.to_hw_sig = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    chk("pending_commits", cq.size(), 0);
    chk("pending_acks", aq.size(), 0);
    chk("commit_count", commits, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
